sd_cmd_phy: RTL and testbench

SD_CMD_PHY -- requirements
Module: sd_cmd_phy

---
 rtl/sd_cmd_phy_pkg.sv | 30 +++
 rtl/sd_cmd_phy_crc.sv | 19 +
 rtl/sd_cmd_phy.sv | 162 ++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_phy_pkg.sv
// Shared SD command-path definitions: frame geometry, CRC7 polynomial and
// the command PHY state encoding.
package sd_cmd_phy_pkg;

    localparam int FRAME_LEN = 48;
    localparam int CMD_W     = 40;
    localparam int CRC_W     = 7;

    // x^7 + x^3 + 1, implicit x^7 term
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        SEND,
        TURN,
        WAIT_RESP,
        RECV,
        HANDOFF,
        RELEASE
    } phy_state_e;

    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
        logic fb;
        fb = din ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_cmd_phy_crc.sv
// Bit-serial CRC7 accumulator; clear wins over enable.
module sd_crc7
    import sd_cmd_phy_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)   crc <= '0;
        else if (clr) crc <= '0;
        else if (en)  crc <= crc7_step(crc, din);
    end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: serialises a 48-bit command with CRC7, then waits for and
// deserialises a 48-bit response, with 4-phase handshakes on both sides.
module sd_cmd_phy
    import sd_cmd_phy_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int NCR_MIN      = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_in,
    output logic             ack_out,
    input  logic [CMD_W-1:0] cmd_in,
    output logic             req_out,
    input  logic             ack_in,
    output logic [CMD_W-1:0] cmd_out,
    output logic             cmd_pin_out,
    output logic             cmd_pin_oe,
    input  logic             cmd_pin_in,
    output logic             timeout_out,
    output logic             crc_err_out,
    output logic             idle_out
);

    localparam int TMAX = (RESP_TIMEOUT > NCR_MIN) ? RESP_TIMEOUT : NCR_MIN;
    localparam int TW   = $clog2(TMAX + 1);

    phy_state_e           state, state_nxt;
    logic [5:0]           bit_cnt;
    logic [TW-1:0]        timer;
    logic [CMD_W-1:0]     tx_sr;
    logic [FRAME_LEN-2:0] rx_sr;
    logic [CRC_W-1:0]     crc;
    logic                 crc_clr, crc_en, crc_din;
    logic [2:0]           crc_sel;

    wire turn_done = (timer == TW'(NCR_MIN - 1));
    wire resp_tmo  = (timer == TW'(RESP_TIMEOUT - 1));

    sd_crc7 u_crc (
        .clock (clock),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );

    // Transmit uses the CRC over the 40 command bits; the same engine is
    // cleared in TURN and reused for bits 47..8 of the response.
    always_comb begin
        crc_clr = (state == IDLE && req_in) || (state == TURN);
        crc_en  = ((state == SEND || state == RECV) && bit_cnt < 6'd40)
                || (state == WAIT_RESP && !cmd_pin_in);
        crc_din = (state == SEND) ? tx_sr[CMD_W-1] : cmd_pin_in;
        crc_sel = 3'(6'd46 - bit_cnt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ack_out     = 1'b0;
        req_out     = 1'b0;
        idle_out    = 1'b0;
        cmd_pin_oe  = 1'b0;
        cmd_pin_out = 1'b1;
        case (state)
            IDLE: begin
                idle_out = 1'b1;
                if (req_in) state_nxt = ACK;
            end
            ACK: begin
                ack_out = 1'b1;
                if (!req_in) state_nxt = SEND;
            end
            SEND: begin
                cmd_pin_oe = 1'b1;
                if (bit_cnt < 6'd40)      cmd_pin_out = tx_sr[CMD_W-1];
                else if (bit_cnt < 6'd47) cmd_pin_out = crc[crc_sel];
                if (bit_cnt == 6'd47) state_nxt = TURN;
            end
            TURN: begin
                if (turn_done) state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (!cmd_pin_in)   state_nxt = RECV;
                else if (resp_tmo) state_nxt = HANDOFF;
            end
            RECV: begin
                if (bit_cnt == 6'd47) state_nxt = HANDOFF;
            end
            HANDOFF: begin
                req_out = 1'b1;
                if (ack_in) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!ack_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= '0;
            timer       <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            cmd_out     <= '0;
            timeout_out <= 1'b0;
            crc_err_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_in) begin
                    tx_sr       <= cmd_in;
                    cmd_out     <= '0;
                    timeout_out <= 1'b0;
                    crc_err_out <= 1'b0;
                    bit_cnt     <= '0;
                    timer       <= '0;
                end
                SEND: begin
                    if (bit_cnt < 6'd40) tx_sr <= {tx_sr[CMD_W-2:0], 1'b0};
                    if (bit_cnt == 6'd47) begin
                        bit_cnt <= '0;
                        timer   <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                TURN: timer <= turn_done ? '0 : timer + 1'b1;
                WAIT_RESP: begin
                    if (!cmd_pin_in) begin
                        rx_sr   <= {rx_sr[FRAME_LEN-3:0], cmd_pin_in};
                        bit_cnt <= 6'd1;
                    end else if (resp_tmo) begin
                        timeout_out <= 1'b1;
                        cmd_out     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RECV: begin
                    if (bit_cnt == 6'd47) begin
                        // rx_sr now holds bits 47..1; the line carries bit 0
                        cmd_out     <= rx_sr[FRAME_LEN-2:CRC_W];
                        crc_err_out <= (crc != rx_sr[CRC_W-1:0]) || !cmd_pin_in;
                    end else begin
                        rx_sr   <= {rx_sr[FRAME_LEN-3:0], cmd_pin_in};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Scoreboarded bench for sd_cmd_phy: a host/card driver pushes expected serial
// frames and responses; independent monitors pop and compare.
module tb_sd_cmd_phy;

    localparam int RT  = 24;
    localparam int NCR = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_in = 1'b0;
    logic        ack_in = 1'b0;
    logic        cmd_pin_in = 1'b1;
    logic [39:0] cmd_in = '0;
    logic        ack_out, req_out, cmd_pin_out, cmd_pin_oe;
    logic        timeout_out, crc_err_out, idle_out;
    logic [39:0] cmd_out;

    sd_cmd_phy #(.RESP_TIMEOUT(RT), .NCR_MIN(NCR)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_in      (req_in),
        .ack_out     (ack_out),
        .cmd_in      (cmd_in),
        .req_out     (req_out),
        .ack_in      (ack_in),
        .cmd_out     (cmd_out),
        .cmd_pin_out (cmd_pin_out),
        .cmd_pin_oe  (cmd_pin_oe),
        .cmd_pin_in  (cmd_pin_in),
        .timeout_out (timeout_out),
        .crc_err_out (crc_err_out),
        .idle_out    (idle_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [39:0] cmd;
        logic        to;
        logic        ce;
    } rsp_t;

    logic [47:0] tx_q[$];
    rsp_t        rsp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // CRC7 as polynomial remainder of msg * x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc_model(input logic [39:0] msg);
        logic [46:0] m;
        m = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    function automatic logic [47:0] frame_of(input logic [39:0] c);
        return {c, crc_model(c), 1'b1};
    endfunction

    function automatic logic resp_bad(input logic [47:0] r);
        return (crc_model(r[47:8]) != r[7:1]) || !r[0];
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return ack_out;
            1:       return cmd_pin_oe;
            2:       return req_out;
            default: return idle_out;
        endcase
    endfunction

    task automatic wait_for(input int w, input logic v, input string nm);
        int n;
        n = 0;
        while (sig(w) !== v && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (sig(w) !== v) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_%s: got %b expected %b after %0d clocks", nm, sig(w), v, n);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ack"},   48'(ack_out),     48'd0);
        chk({nm, "_req"},   48'(req_out),     48'd0);
        chk({nm, "_cmd"},   48'(cmd_out),     48'd0);
        chk({nm, "_pin"},   48'(cmd_pin_out), 48'd1);
        chk({nm, "_oe"},    48'(cmd_pin_oe),  48'd0);
        chk({nm, "_to"},    48'(timeout_out), 48'd0);
        chk({nm, "_crc"},   48'(crc_err_out), 48'd0);
        chk({nm, "_idle"},  48'(idle_out),    48'd1);
    endtask

    // mode 0: card silent; mode 1: card replies with resp after dly clocks
    task automatic run_cmd(input logic [39:0] cmd, input logic [47:0] exp_frame,
                           input int mode, input logic [47:0] resp, input int dly,
                           input int hold, input bit pulse);
        rsp_t r;
        int   n;
        tx_q.push_back(exp_frame);
        if (mode == 0) r = '{cmd: '0, to: 1'b1, ce: 1'b0};
        else           r = '{cmd: resp[47:8], to: 1'b0, ce: resp_bad(resp)};
        rsp_q.push_back(r);
        @(negedge clock);
        cmd_in = cmd;
        req_in = 1'b1;
        wait_for(0, 1'b1, "ack_rise");
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (hold >= 10) begin
                chk("ack_held", 48'(ack_out), 48'd1);
                chk("send_held_off", 48'(cmd_pin_oe), 48'd0);
            end
        end
        req_in = 1'b0;
        cmd_in = 40'({$urandom(), $urandom()});
        wait_for(1, 1'b1, "oe_rise");
        wait_for(1, 1'b0, "oe_fall");
        if (mode == 0) begin
            n = 0;
            while (!req_out && n < 1000) begin
                @(negedge clock);
                n++;
            end
            chk("timeout_latency", 48'(n), 48'(NCR + RT));
        end else begin
            repeat (NCR + dly) @(negedge clock);
            for (int i = 47; i >= 0; i--) begin
                if (pulse && i <= 36 && i >= 34)
                    chk("ack_during_recv", 48'(ack_out), 48'd0);
                cmd_pin_in = resp[i];
                req_in = pulse && i <= 37 && i >= 35;
                @(negedge clock);
            end
            cmd_pin_in = 1'b1;
            req_in = 1'b0;
        end
        wait_for(2, 1'b1, "req_rise");
        repeat ($urandom_range(0, 3)) @(negedge clock);
        ack_in = 1'b1;
        wait_for(2, 1'b0, "req_fall");
        ack_in = 1'b0;
        wait_for(3, 1'b1, "idle");
    endtask

    // serial frame monitor
    logic [47:0] fr;
    int          nbits = 0;
    always @(negedge clock) begin
        if (!reset) begin
            nbits = 0;
        end else if (cmd_pin_oe) begin
            fr = {fr[46:0], cmd_pin_out};
            nbits++;
        end else if (nbits > 0) begin
            chk("oe_len", 48'(nbits), 48'd48);
            chk("pin_released", 48'(cmd_pin_out), 48'd1);
            if (tx_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL frame_unexpected: got %h expected none", fr);
            end else begin
                chk("tx_frame", fr, tx_q.pop_front());
            end
            nbits = 0;
        end
    end

    // response monitor
    bit seen = 1'b0;
    always @(negedge clock) begin
        rsp_t e;
        if (req_out && !seen) begin
            seen = 1'b1;
            if (rsp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_unexpected: got %h expected none", cmd_out);
            end else begin
                e = rsp_q.pop_front();
                chk("cmd_out", 48'(cmd_out), 48'(e.cmd));
                chk("timeout_out", 48'(timeout_out), 48'(e.to));
                chk("crc_err_out", 48'(crc_err_out), 48'(e.ce));
            end
        end
        if (!req_out) seen = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] c;
        logic [47:0] rsp;
        int          k;

        repeat (2) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // CMD0, card silent
        run_cmd(40'h40_0000_0000, 48'h40_0000_0000_95, 0, '0, 0, 1, 1'b0);

        // CMD8; card reply carries its own CRC7 over 08_0000_01AA
        rsp = frame_of(40'h08_0000_01AA);
        run_cmd(40'h48_0000_01AA, 48'h48_0000_01AA_87, 1, rsp, 3, 0, 1'b0);

        // one CRC bit flipped
        rsp[4] = ~rsp[4];
        run_cmd(40'h48_0000_01AA, 48'h48_0000_01AA_87, 1, rsp, 0, 2, 1'b0);

        // bad end bit, latest allowed start bit
        rsp = frame_of(40'h11_2233_4455) & ~48'd1;
        run_cmd(40'h51_0000_0000, frame_of(40'h51_0000_0000), 1, rsp, RT - 1, 1, 1'b0);

        // req_in held long in ACK, req_in pulsed during RECV
        rsp = frame_of(40'h37_DEAD_BEEF);
        run_cmd(40'h77_0000_0000, frame_of(40'h77_0000_0000), 1, rsp, 5, 10, 1'b1);

        // reset at bit 20 of SEND
        @(negedge clock);
        cmd_in = 40'h52_1234_5678;
        req_in = 1'b1;
        wait_for(0, 1'b1, "ack_rise_rst");
        req_in = 1'b0;
        wait_for(1, 1'b1, "oe_rise_rst");
        repeat (20) @(negedge clock);
        #1 reset = 1'b0;
        #1 chk_reset_outputs("midframe_reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        rsp = frame_of(40'h12_0000_0900);
        run_cmd(40'h52_1234_5678, frame_of(40'h52_1234_5678), 1, rsp, 1, 0, 1'b0);

        for (int it = 0; it < 16; it++) begin
            c   = {2'b01, 6'($urandom()), 32'($urandom())};
            rsp = frame_of({2'b00, c[37:32], 32'($urandom())});
            k   = $urandom_range(0, 2);
            if (k == 1) rsp[$urandom_range(0, 46)] ^= 1'b1;
            if (k == 2) rsp[0] = 1'b0;
            run_cmd(c, frame_of(c), ($urandom_range(0, 3) == 0) ? 0 : 1, rsp,
                    $urandom_range(0, RT - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clock);
        chk("tx_q_drained", 48'(tx_q.size()), 48'd0);
        chk("rsp_q_drained", 48'(rsp_q.size()), 48'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
